// File: rtl/simmem_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// simmem_pkg: shared widths and slot record for the simulated memory controller
// Revision 1.0
// ----------------------------------------------------------------------------
package simmem_pkg;

  localparam int NumIds          = 16;
  localparam int DefIdWidth      = $clog2(NumIds);
  localparam int DefCapacity     = 64;
  localparam int DefCounterWidth = 8;
  localparam int RankWidth       = $clog2(DefCapacity);

  typedef struct packed {
    logic                       valid;
    logic [DefIdWidth-1:0]      id;
    logic [DefCounterWidth-1:0] cnt;
    logic [RankWidth-1:0]       rank;
  } delay_slot_t;

endpackage
`default_nettype wire

// File: rtl/simmem_delay_tracker_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// simmem_delay_tracker_if: request / release handshake bundle of the tracker
// Revision 1.0
// ----------------------------------------------------------------------------
interface simmem_delay_tracker_if #(
  parameter int TotalCapacity = simmem_pkg::DefCapacity,
  parameter int IDWidth       = simmem_pkg::DefIdWidth,
  parameter int CounterWidth  = simmem_pkg::DefCounterWidth
);

  localparam int NumIdsP = 2 ** IDWidth;
  localparam int OccW    = $clog2(TotalCapacity + 1);

  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [IDWidth-1:0]      in_id_i;
  logic [CounterWidth-1:0] in_delay_i;
  logic [NumIdsP-1:0]      release_en_o;
  logic                    rel_valid_i;
  logic [IDWidth-1:0]      rel_id_i;
  logic [OccW-1:0]         occupancy_o;

  modport slave (
    input  in_valid_i, in_id_i, in_delay_i, rel_valid_i, rel_id_i,
    output in_ready_o, release_en_o, occupancy_o
  );

  modport master (
    output in_valid_i, in_id_i, in_delay_i, rel_valid_i, rel_id_i,
    input  in_ready_o, release_en_o, occupancy_o
  );

endinterface
`default_nettype wire

// File: rtl/simmem_delay_tracker_slot.sv
`default_nettype none
// ----------------------------------------------------------------------------
// simmem_delay_slot: one tracked request (id, delay countdown, same-ID age rank)
// Revision 1.0
// ----------------------------------------------------------------------------
module simmem_delay_slot
  import simmem_pkg::*;
#(
  parameter int IDWidth       = DefIdWidth,
  parameter int CounterWidth  = DefCounterWidth,
  parameter int SlotRankWidth = RankWidth,
  parameter int DelayFromHead = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     alloc_i,
  input  logic [IDWidth-1:0]       alloc_id_i,
  input  logic [CounterWidth-1:0]  alloc_delay_i,
  input  logic [SlotRankWidth-1:0] alloc_rank_i,
  input  logic                     rel_i,
  input  logic [IDWidth-1:0]       rel_id_i,
  output logic                     valid_o,
  output logic [IDWidth-1:0]       id_o,
  output logic                     head_o,
  output logic                     expired_o
);

  localparam logic [CounterWidth-1:0]  CntOne  = CounterWidth'(1);
  localparam logic [SlotRankWidth-1:0] RankOne = SlotRankWidth'(1);

  logic                     valid_d, valid_q;
  logic [IDWidth-1:0]       id_d, id_q;
  logic [CounterWidth-1:0]  cnt_d, cnt_q;
  logic [SlotRankWidth-1:0] rank_d, rank_q;

  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    rank_d  = rank_q;
    if (valid_q) begin
      // Saturating countdown; in head-gated mode only the head ages.
      if ((cnt_q != '0) && ((DelayFromHead == 0) || (rank_q == '0))) begin
        cnt_d = cnt_q - CntOne;
      end
      if (rel_i && (id_q == rel_id_i)) begin
        if (rank_q == '0) begin
          valid_d = 1'b0;
        end else begin
          rank_d = rank_q - RankOne;
        end
      end
    end else if (alloc_i) begin
      valid_d = 1'b1;
      id_d    = alloc_id_i;
      cnt_d   = alloc_delay_i;
      rank_d  = alloc_rank_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      id_q    <= '0;
      cnt_q   <= '0;
      rank_q  <= '0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      rank_q  <= rank_d;
    end
  end

  assign valid_o   = valid_q;
  assign id_o      = id_q;
  assign head_o    = valid_q && (rank_q == '0);
  assign expired_o = valid_q && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/simmem_delay_tracker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// simmem_delay_tracker: per-ID delay tracker releasing requests in ID order
// Revision 1.0
// ----------------------------------------------------------------------------
module simmem_delay_tracker
  import simmem_pkg::*;
#(
  parameter int TotalCapacity = DefCapacity,
  parameter int IDWidth       = DefIdWidth,
  parameter int CounterWidth  = DefCounterWidth,
  parameter int DelayFromHead = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  simmem_delay_tracker_if.slave bus
);

  localparam int NumIdsP = 2 ** IDWidth;
  localparam int RankW   = (TotalCapacity > 1) ? $clog2(TotalCapacity) : 1;
  localparam int OccW    = $clog2(TotalCapacity + 1);

  localparam logic [OccW-1:0]  OccOne  = OccW'(1);
  localparam logic [OccW-1:0]  OccFull = OccW'(TotalCapacity);
  localparam logic [RankW-1:0] RankOne = RankW'(1);

  logic [TotalCapacity-1:0] slot_valid;
  logic [TotalCapacity-1:0] slot_head;
  logic [TotalCapacity-1:0] slot_expired;
  logic [TotalCapacity-1:0] alloc_sel;
  logic [IDWidth-1:0]       slot_id [TotalCapacity];
  logic [RankW-1:0]         alloc_rank;
  logic [NumIdsP-1:0]       release_en;
  logic                     free_found;
  logic                     in_ready;
  logic                     alloc_fire;
  logic                     rel_fire;
  logic [OccW-1:0]          occ_d, occ_q;

  assign in_ready   = (occ_q != OccFull);
  assign alloc_fire = bus.in_valid_i && in_ready;
  assign rel_fire   = bus.rel_valid_i && release_en[bus.rel_id_i];

  // Lowest-index free slot; a slot freed this cycle still reads valid here.
  always_comb begin
    free_found = 1'b0;
    alloc_sel  = '0;
    for (int i = 0; i < TotalCapacity; i++) begin
      if (!slot_valid[i] && !free_found) begin
        alloc_sel[i] = 1'b1;
        free_found   = 1'b1;
      end
    end
  end

  // Rank = older same-ID requests that will still be outstanding next cycle.
  always_comb begin
    alloc_rank = '0;
    for (int i = 0; i < TotalCapacity; i++) begin
      if (slot_valid[i] && (slot_id[i] == bus.in_id_i)) begin
        alloc_rank = alloc_rank + RankOne;
      end
    end
    if (rel_fire && (bus.rel_id_i == bus.in_id_i)) begin
      alloc_rank = alloc_rank - RankOne;
    end
  end

  always_comb begin
    release_en = '0;
    for (int j = 0; j < NumIdsP; j++) begin
      for (int i = 0; i < TotalCapacity; i++) begin
        if (slot_head[i] && slot_expired[i] && (slot_id[i] == IDWidth'(j))) begin
          release_en[j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (alloc_fire && !rel_fire) begin
      occ_d = occ_q + OccOne;
    end else if (!alloc_fire && rel_fire) begin
      occ_d = occ_q - OccOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  for (genvar g = 0; g < TotalCapacity; g++) begin : g_slot
    simmem_delay_slot #(
      .IDWidth       (IDWidth),
      .CounterWidth  (CounterWidth),
      .SlotRankWidth (RankW),
      .DelayFromHead (DelayFromHead)
    ) u_slot (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .alloc_i       (alloc_fire && alloc_sel[g]),
      .alloc_id_i    (bus.in_id_i),
      .alloc_delay_i (bus.in_delay_i),
      .alloc_rank_i  (alloc_rank),
      .rel_i         (rel_fire),
      .rel_id_i      (bus.rel_id_i),
      .valid_o       (slot_valid[g]),
      .id_o          (slot_id[g]),
      .head_o        (slot_head[g]),
      .expired_o     (slot_expired[g])
    );
  end

  assign bus.in_ready_o   = in_ready;
  assign bus.release_en_o = release_en;
  assign bus.occupancy_o  = occ_q;

endmodule
`default_nettype wire

// File: doc/simmem_delay_tracker.md
# simmem_delay_tracker

Parametrised per-ID delay tracker for the simulated memory controller. Each accepted request gets a slot holding its ID, a delay counter and its age rank among same-ID requests. `release_en_o[id]` asserts only when the oldest outstanding request of that ID has finished its delay, which preserves per-ID ordering. Sits between the request-side ID/delay computation and the response banks, which consume releases through an explicit acknowledge.

## Interface

- `TotalCapacity`, default 64: number of slots, ≥2.
- `IDWidth`, default 4: ID width; `NumIds = 2**IDWidth`.
- `CounterWidth`, default 8: delay counter width, in cycles.
- `DelayFromHead`, default 0: 0 counts down from allocation; 1 counts only while the slot is head of its ID.

Ports:

- `clk_i` in 1: clock. Reset is synchronous and active-low.
- `rst_ni` in 1: synchronous active-low reset.
- `in_valid_i` in 1: new request valid.
- `in_ready_o` out 1: a free slot exists.
- `in_id_i` in IDWidth: request ID.
- `in_delay_i` in CounterWidth: delay in cycles.
- `release_en_o` out NumIds: head of the ID is expired and releasable.
- `rel_valid_i` in 1: release acknowledge, frees the head of `rel_id_i`.
- `rel_id_i` in IDWidth: ID being released.
- `occupancy_o` out $clog2(TotalCapacity+1): number of occupied slots.

## Operation

- Slot state: `valid`, `id`, `cnt[CounterWidth]`, `rank[$clog2(TotalCapacity)]`. The head of an ID is its valid slot with `rank==0`.
- Allocation: on `in_valid_i && in_ready_o`, write the lowest-index free slot.
  - `cnt = in_delay_i`.
  - `rank` = number of valid slots with the same ID, minus 1 if a release of that ID occurs in the same cycle.
- Countdown: each cycle, a valid slot with `cnt!=0` decrements. With `DelayFromHead=1`, it decrements only while `rank==0`. The counter saturates at 0 and never wraps.
- Expired means `valid && cnt==0`. `release_en_o[i] = |(valid && id==i && rank==0 && cnt==0)`. This is combinational from registered state.
- Release: on `rel_valid_i` with `release_en_o[rel_id_i]==1`:
  - the head slot of `rel_id_i` clears `valid`;
  - every other valid slot of that ID decrements `rank`.
  - If `release_en_o[rel_id_i]==0`, `rel_valid_i` is ignored: no state change.
- `in_ready_o = occupancy_o != TotalCapacity`. A slot freed in cycle T is allocatable from T+1, never in the same cycle.
- `occupancy_o` = count of valid slots. It is updated by +1 on allocation and −1 on release, and stays unchanged when both happen in the same cycle.
- Reset (at any time, including mid-operation): all `valid=0`, `cnt=0`, `rank=0`. Outputs after reset: `in_ready_o=1`, `release_en_o=0`, `occupancy_o=0`. In-flight requests are discarded.

## Timing

- Allocation accepted in cycle T with delay D and `DelayFromHead=0`: the slot is expired from cycle T+1+D. `release_en_o` rises at T+1+D if the slot is head.
- D=0: expired at T+1.
- `DelayFromHead=1`: counting starts the cycle after the slot becomes head. A slot that is already head at allocation behaves like mode 0.
- Release acknowledged in cycle T: `release_en_o[id]` reflects the next head at T+1. It stays low until that head has expired.
- Simultaneous allocation and release of the same ID: the new slot's rank accounts for the release, so no rank hole is created.
- At most one allocation and one release per cycle.

## Structure

- Shared package `simmem_pkg`:
  - slot struct typedef `delay_slot_t`, parametrised through localparams;
  - localparams `NumIds` and `RankWidth`.
- One sub-module `simmem_delay_slot`, instantiated TotalCapacity times. It holds one slot's valid/id/cnt/rank registers, decrement logic and head/expired flags.
- The top level holds the lowest-free-slot priority encoder, the same-ID population count for rank, the per-ID OR reduction for `release_en_o`, and the occupancy counter.

## Test plan

- Reset, then a single request with ID 3 and D=5 accepted at cycle 0: `release_en_o[3]` rises at cycle 6. `rel_valid_i` at cycle 7 → `release_en_o[3]=0` and `occupancy_o=0` at cycle 8.
- Ordering, same ID 2: requests with D=10 then D=1 in consecutive cycles.
  - `release_en_o[2]` rises only when the first request expires (cycle 11).
  - After releasing it, the flag reasserts the next cycle for the second request, which is already expired.
- Fill `TotalCapacity` slots with D=255: `in_ready_o=0`, `occupancy_o=TotalCapacity`, and a further `in_valid_i` is not accepted. One release re-raises `in_ready_o` the next cycle.
- `rel_valid_i` for an ID with `release_en_o` low, or with no entries: no change to occupancy or flags.
- Same-cycle allocation and release of ID 1: the new slot gets the correct rank (flag sequence matches the reference model) and occupancy is unchanged.
- `DelayFromHead=1`: two ID-0 requests with D=4 each; the second releases 5 cycles after the first's release. Reset asserted mid-countdown clears all outputs the next cycle.
